csa_accum: RTL and testbench

CSA_ACCUM -- requirements
Module: csa_accum

---
 rtl/csa_accum.sv | 121 ++++++++++++
 tb/tb_csa_accum.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum.sv
// Carry-save multi-row accumulator.
// Each accepted beat folds m0 + 2*m1 + 4*m2 into a redundant (S, C) pair
// without any carry-propagate path; a single full add resolves the sum
// once the final beat has been taken.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no operation in flight, waiting for the first beat
// ACCUM   | at least one beat taken, waiting for further beats
// RESOLVE | one cycle: carry-propagate S+C into result, latch beat count
// OUT     | result presented, held until out_ready
module csa_accum #(
  parameter int W  = 8,
  parameter int AW = 2*W+4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [W-1:0]  m0,
  input  logic [W-1:0]  m1,
  input  logic [W-1:0]  m2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] result,
  output logic [7:0]    out_beats
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, OUT} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  s_q, s_d;
  logic [AW-1:0]  c_q, c_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [AW-1:0]  result_q, result_d;
  logic [7:0]     beats_q, beats_d;

  logic [AW-1:0]  r0, r1, r2;
  logic [AW-1:0]  row_s, row_c;
  logic [AW-1:0]  mrg_s, mrg_c;
  logic [AW-1:0]  acc_s, acc_c;

  // Align the three input rows at their weights; AW >= W+3 keeps m2<<2 in range.
  always_comb begin
    r0 = {{(AW-W){1'b0}}, m0};
    r1 = {{(AW-W){1'b0}}, m1} << 1;
    r2 = {{(AW-W){1'b0}}, m2} << 2;
  end

  // Row compression, then a 4:2 merge of (row_s, row_c) into the accumulator.
  // Carry vectors shift left with a zero LSB; the carry out of the MSB is lost.
  always_comb begin
    row_s = r0 ^ r1 ^ r2;
    row_c = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
    mrg_s = s_q ^ c_q ^ row_s;
    mrg_c = ((s_q & c_q) | (s_q & row_s) | (c_q & row_s)) << 1;
    acc_s = mrg_s ^ mrg_c ^ row_c;
    acc_c = ((mrg_s & mrg_c) | (mrg_s & row_c) | (mrg_c & row_c)) << 1;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    beats_d  = beats_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (in_valid) begin
          s_d     = acc_s;
          c_d     = acc_c;
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          state_d = in_last ? RESOLVE : ACCUM;
        end
      end
      RESOLVE: begin
        result_d = s_q + c_q;
        beats_d  = cnt_q;
        state_d  = OUT;
      end
      OUT: begin
        if (out_ready) begin
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      beats_q  <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      beats_q  <= beats_d;
    end
  end

  // in_ready is gated by rst_n so it drops the instant reset asserts.
  assign in_ready  = rst_n && ((state_q == IDLE) || (state_q == ACCUM));
  assign out_valid = (state_q == OUT);
  assign result    = result_q;
  assign out_beats = beats_q;

endmodule

// File: tb/tb_csa_accum.sv
// Scoreboard bench for csa_accum (W=8, AW=11 so the wrap case is reachable).
module tb_csa_accum;

  localparam int W  = 8;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [W-1:0]  m0, m1, m2;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] result;
  logic [7:0]    out_beats;

  csa_accum #(.W(W), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .m0        (m0),
    .m1        (m1),
    .m2        (m2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_beats (out_beats)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: running integer sum and beat count of the open operation.
  int unsigned acc_m = 0;
  int unsigned cnt_m = 0;
  int unsigned exp_res_q[$];
  int unsigned exp_beats_q[$];

  int ready_mode = 0;  // 0: always ready, 1: random, 2: hold off

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Output acceptance driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom % 2);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every cycle out_valid is high, the head of the scoreboard must
  // be on the outputs; it is popped when the result is taken.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_res_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("result", 32'(result), exp_res_q[0]);
        chk("out_beats", 32'(out_beats), exp_beats_q[0]);
        chk("in_ready_in_out", 32'(in_ready), 0);
        if (out_ready) begin
          void'(exp_res_q.pop_front());
          void'(exp_beats_q.pop_front());
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input bit last);
    int t = 0;
    m0 = a; m1 = b; m2 = c; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("beat_handshake_timeout", 0, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    acc_m = (acc_m + a + 2*b + 4*c) % (1 << AW);
    cnt_m = (cnt_m < 255) ? cnt_m + 1 : 255;
    if (last) begin
      exp_res_q.push_back(acc_m);
      exp_beats_q.push_back(cnt_m);
      acc_m = 0;
      cnt_m = 0;
    end
  endtask

  // Call right after a last beat: out_valid must appear exactly two edges later.
  task automatic check_latency();
    @(negedge clk);
    chk("latency_cycle1", 32'(out_valid), 0);
    @(negedge clk);
    chk("latency_cycle2", 32'(out_valid), 1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_res_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", exp_res_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    rst_n = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    m0 = '0; m1 = '0; m2 = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_out_beats", 32'(out_beats), 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat of all-ones rows: 1785, one beat.
    send_beat(8'hFF, 8'hFF, 8'hFF, 1'b1);
    check_latency();
    drain();

    // Three-beat operation: 798.
    send_beat(8'h01, 8'h01, 8'h01, 1'b0);
    send_beat(8'h02, 8'h03, 8'h04, 1'b0);
    send_beat(8'hFF, 8'h00, 8'h80, 1'b1);
    check_latency();
    drain();

    // Wrap: 3570 mod 2048 = 1522.
    send_beat(8'hFF, 8'hFF, 8'hFF, 1'b0);
    send_beat(8'hFF, 8'hFF, 8'hFF, 1'b1);
    drain();

    // Backpressure with ignored input pulses.
    ready_mode = 2;
    @(posedge clk);
    #1;
    send_beat(8'h01, 8'h02, 8'h03, 1'b1);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_reach_out", 32'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom % 2);
      in_last  = 1'($urandom % 2);
      m0 = 8'($urandom); m1 = 8'($urandom); m2 = 8'($urandom);
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    ready_mode = 0;
    drain();
    chk("idle_after_take", 32'(in_ready), 1);
    send_beat(8'h07, 8'h00, 8'h00, 1'b1);
    drain();

    // Beat-count saturation.
    for (int i = 1; i <= 300; i++) send_beat(8'h00, 8'h00, 8'h00, i == 300);
    drain();

    // Reset in the middle of an operation.
    send_beat(8'h11, 8'h22, 8'h33, 1'b0);
    send_beat(8'h44, 8'h55, 8'h66, 1'b0);
    #2;
    rst_n = 1'b0;
    acc_m = 0;
    cnt_m = 0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(8'h05, 8'h00, 8'h00, 1'b1);
    check_latency();
    drain();

    // Randomized operations with random backpressure.
    ready_mode = 1;
    for (int op = 0; op < 40; op++) begin
      int nb;
      nb = $urandom_range(1, 6);
      for (int b = 1; b <= nb; b++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send_beat(8'($urandom), 8'($urandom), 8'($urandom), b == nb);
      end
    end
    drain();
    ready_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
